bar_graph_sequencer: RTL and testbench

Initiator that drives the single-bar drawer (start_x/start_y/graph_height/enable in, sticky done out, active-low resetn) through a full chart of NUM_BARS bars. On a start pulse it reads each bar height from the price-history RAM and clamps it. It then positions the bar, runs the drawer to completion and clears it before the next bar. It sits between the price-history store and the drawer/VGA plot path.

---
 rtl/bar_graph_sequencer.sv | 105 ++++++++++
 tb/tb_bar_graph_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bar_graph_sequencer.sv
// bar_graph_sequencer: steps a single-bar drawer through NUM_BARS clamped bars read from price RAM.
// Optional SKIP_ZERO_BARS_EN: zero-height bars skip DRAW and go straight from LATCH to NEXT.
module bar_graph_sequencer #(
    parameter int NUM_BARS   = 8,
    parameter int ORIGIN_X   = 20,
    parameter int BAR_PITCH  = 10,
    parameter int BASELINE_Y = 220,
    parameter int MAX_HEIGHT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] height_addr,
    input  logic [7:0] height_data,
    output logic [8:0] draw_start_x,
    output logic [7:0] draw_start_y,
    output logic [7:0] draw_height,
    output logic       draw_enable,
    output logic       draw_resetn,
    input  logic       draw_done,
    output logic       busy,
    output logic       done,
    output logic [3:0] bar_index
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LATCH, DRAW, NEXT, FINISH} state_t;
    state_t     state, nxt_state;
    logic [3:0] nxt_bar, nxt_addr;
    logic [8:0] nxt_x;
    logic [7:0] nxt_h;
    logic       nxt_en, nxt_rn, nxt_busy, nxt_done, skip;
`ifdef SKIP_ZERO_BARS_EN
    assign skip = height_data == 8'd0;
`else
    assign skip = 1'b0;
`endif
    assign draw_start_y = 8'(BASELINE_Y);
    // Every output is the registered image of the value decoded for the next state.
    always_comb begin
        nxt_state = state;
        nxt_bar   = bar_index;
        nxt_addr  = height_addr;
        nxt_x     = draw_start_x;
        nxt_h     = draw_height;
        nxt_en    = 1'b0;
        nxt_rn    = 1'b1;
        nxt_busy  = busy;
        nxt_done  = 1'b0;
        case (state)
            IDLE: if (start) begin
                nxt_state = CLEAR;
                nxt_bar   = 4'd0;
                nxt_rn    = 1'b0;
                nxt_busy  = 1'b1;
            end
            CLEAR: begin
                nxt_state = FETCH;
                nxt_addr  = bar_index;
                nxt_x     = 9'(ORIGIN_X + 32'(bar_index) * BAR_PITCH);
            end
            FETCH: nxt_state = LATCH;
            LATCH: begin
                nxt_h     = (height_data > 8'(MAX_HEIGHT)) ? 8'(MAX_HEIGHT) : height_data;
                nxt_state = skip ? NEXT : DRAW;
                nxt_en    = !skip;
            end
            DRAW: begin
                nxt_state = draw_done ? NEXT : DRAW;
                nxt_en    = !draw_done;
            end
            NEXT: if (bar_index == 4'(NUM_BARS - 1)) begin
                nxt_state = FINISH;
                nxt_done  = 1'b1;
                nxt_busy  = 1'b0;
            end else begin
                nxt_state = CLEAR;
                nxt_bar   = bar_index + 4'd1;
                nxt_rn    = 1'b0;
            end
            default: nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bar_index    <= 4'd0;
            height_addr  <= 4'd0;
            draw_start_x <= 9'(ORIGIN_X);
            draw_height  <= 8'd0;
            draw_enable  <= 1'b0;
            draw_resetn  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= nxt_state;
            bar_index    <= nxt_bar;
            height_addr  <= nxt_addr;
            draw_start_x <= nxt_x;
            draw_height  <= nxt_h;
            draw_enable  <= nxt_en;
            draw_resetn  <= nxt_rn;
            busy         <= nxt_busy;
            done         <= nxt_done;
        end
    end
endmodule

// File: tb/tb_bar_graph_sequencer.sv
// tb_bar_graph_sequencer: scoreboard bench with RAM and drawer models for bar_graph_sequencer.
module tb_bar_graph_sequencer;
    localparam int NB = 8, OX = 20, PITCH = 10, BY = 220, MAXH = 200;
    logic       clk = 0, reset = 1, start = 0;
    logic [3:0] height_addr, bar_index;
    logic [7:0] height_data = 0, draw_start_y, draw_height;
    logic [8:0] draw_start_x;
    logic       draw_enable, draw_resetn, draw_done = 0, busy, done;
    int total = 0, bad = 0, done_cnt = 0;
    int ram[16];
    int qb[$], qx[$], qh[$];
    int dcnt = 0, dtgt = 1;
    bit en_q = 0, done_q = 0;
    int run = 0, last_run = 0;

    bar_graph_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .height_addr(height_addr),
        .height_data(height_data), .draw_start_x(draw_start_x), .draw_start_y(draw_start_y),
        .draw_height(draw_height), .draw_enable(draw_enable), .draw_resetn(draw_resetn),
        .draw_done(draw_done), .busy(busy), .done(done), .bar_index(bar_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) height_data <= 8'(ram[height_addr]);

    // Drawer: finishes after a random number of enabled cycles, done sticky until resetn low.
    always @(posedge clk) begin
        if (!draw_resetn) begin
            dcnt      <= 0;
            draw_done <= 1'b0;
            dtgt      <= $urandom_range(1, 5);
        end else if (draw_enable && !draw_done) begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 >= dtgt) draw_done <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising draw_enable is one bar presented to the drawer.
    always @(negedge clk) begin
        if (!draw_resetn) run++;
        else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (!reset) begin
            if (draw_enable && !en_q) begin
                if (qb.size() == 0) check("unexpected_draw", 1, 0);
                else begin
                    check("bar_index", int'(bar_index), qb.pop_front());
                    check("start_x", int'(draw_start_x), qx.pop_front());
                    check("height", int'(draw_height), qh.pop_front());
                    check("start_y", int'(draw_start_y), BY);
                    check("busy_in_draw", int'(busy), 1);
                    check("resetn_low_run", last_run, 1);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_single_cycle", int'(done_q), 0);
                check("busy_at_done", int'(busy), 0);
                check("bars_left_at_done", qb.size(), 0);
            end
        end
        en_q   = draw_enable;
        done_q = done;
    end

    task automatic run_chart(input int mode);
        int d0;
        bit hit;
        for (int i = 0; i < NB; i++) begin
`ifdef SKIP_ZERO_BARS_EN
            if (ram[i] == 0) continue;
`endif
            qb.push_back(i);
            qx.push_back(OX + i * PITCH);
            qh.push_back(ram[i] > MAXH ? MAXH : ram[i]);
        end
        d0 = done_cnt;
        hit = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
            @(negedge clk);
            if (!hit && mode != 0 && draw_enable && int'(bar_index) == (mode == 1 ? 2 : 5)) begin
                hit = 1;
                if (mode == 1) begin
                    start = 1;
                    @(negedge clk);
                    start = 0;
                end else begin
                    reset = 1;
                    @(negedge clk);
                    check("rst_enable", int'(draw_enable), 0);
                    check("rst_resetn", int'(draw_resetn), 0);
                    check("rst_busy", int'(busy), 0);
                    check("rst_bar_index", int'(bar_index), 0);
                    qb.delete(); qx.delete(); qh.delete();
                    reset = 0;
                    repeat (30) @(negedge clk);
                    check("no_done_after_reset", done_cnt - d0, 0);
                    return;
                end
            end
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("queue_drained", qb.size(), 0);
    endtask

    task automatic fill_random(input int lo);
        for (int i = 0; i < 16; i++) ram[i] = $urandom_range(lo, 255);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 0;
        repeat (3) @(negedge clk);
        check("reset_resetn", int'(draw_resetn), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_enable", int'(draw_enable), 0);
        check("reset_start_x", int'(draw_start_x), OX);
        check("reset_height", int'(draw_height), 0);
        reset = 0;
        @(negedge clk);
        check("resetn_after_reset", int'(draw_resetn), 1);
        check("idle_busy", int'(busy), 0);
        for (int i = 0; i < NB; i++) ram[i] = 10 * (i + 1);
        run_chart(0);
        fill_random(0);
        ram[1] = 0; ram[3] = 250; ram[4] = 200; ram[5] = 201; ram[6] = 199;
        run_chart(0);
        fill_random(1);
        run_chart(1);
        fill_random(1);
        run_chart(2);
        fill_random(0);
        run_chart(0);
        for (int k = 0; k < 4; k++) begin
            fill_random(0);
            ram[$urandom_range(0, NB - 1)] = 0;
            run_chart(0);
        end
        check("idle_at_end", int'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
